// File: rtl/toggle_handshake_rx.sv
// toggle_handshake_rx: destination side of a two-phase toggle handshake.
// Synchronises the sender's request toggle, captures the data word on each
// toggle edge, offers it on a valid/ready interface and returns an
// acknowledge toggle once the word is consumed.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no word held; waiting for a request toggle edge
// VALID | word held on out_data; waiting for out_ready to consume it
module toggle_handshake_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_tgl,
   input  logic [DATA_W-1:0] req_data,
   output logic              ack_tgl,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  evt_count,
   output logic              proto_err
);

   typedef enum logic {
      IDLE  = 1'b0,
      VALID = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   logic                   req_prev;
   logic                   req_edge;
   logic                   take_word;
   logic                   done;

   // Plain flop chain on the asynchronous request toggle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
      end
   end

   assign req_s    = sync_q[SYNC_STAGES-1];
   assign req_edge = req_s ^ req_prev;

   // Previous synchronised level, tracked in every state so that an edge
   // arriving while VALID is a one-cycle pulse and is dropped naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_prev <= 1'b0;
      end else begin
         req_prev <= req_s;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_edge)  state_nxt = VALID;
         VALID:   if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output and strobe decode from the current state.
   always_comb begin
      out_valid = 1'b0;
      take_word = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            take_word = req_edge;
         end
         VALID: begin
            out_valid = 1'b1;
            done      = out_ready;
         end
         default: begin
            out_valid = 1'b0;
         end
      endcase
   end

   // Data capture happens only on the IDLE->VALID transition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data <= '0;
      end else if (take_word) begin
         out_data <= req_data;
      end
   end

   // Acknowledge toggle and consumed-word counter advance on each handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_tgl   <= 1'b0;
         evt_count <= '0;
      end else if (done) begin
         ack_tgl   <= ~ack_tgl;
         evt_count <= evt_count + 1'b1;
      end
   end

   // Sticky flag for a request arriving before the previous one was acked.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         proto_err <= 1'b0;
      end else if ((state == VALID) && req_edge) begin
         proto_err <= 1'b1;
      end
   end

endmodule
